// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC stored-program machine: opcodes, FSM states
// and instruction field geometry.
package risc_spm_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd3;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'd4;
    localparam logic [OPC_W-1:0] OP_RD   = 4'd5;
    localparam logic [OPC_W-1:0] OP_WR   = 4'd6;
    localparam logic [OPC_W-1:0] OP_BR   = 4'd7;
    localparam logic [OPC_W-1:0] OP_BRZ  = 4'd8;
    localparam logic [OPC_W-1:0] OP_BRC  = 4'd9;
    localparam logic [OPC_W-1:0] OP_CMP  = 4'd10;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'd11;
    localparam logic [OPC_W-1:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DEC,
        S_EX,
        S_OPND,
        S_DATA,
        S_HALT
    } state_e;

    // Width of each register-select field; the opcode takes the remaining 4 bits.
    function automatic int rsel_w(input int word_w);
        return (word_w - OPC_W) / 2;
    endfunction

endpackage

// File: rtl/risc_alu_gen2.sv
// Combinational ALU: ADD/SUB/AND/NOT/CMP with zero and carry/borrow generation.
module risc_alu_gen2
    import risc_spm_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic [OPC_W-1:0]  i_op,
    input  logic [WORD_W-1:0] i_dst_val,
    input  logic [WORD_W-1:0] i_src_val,
    input  logic              i_c,
    output logic [WORD_W-1:0] o_res,
    output logic              o_c,
    output logic              o_z,
    output logic              o_we
);

    logic [WORD_W:0] w_sum;
    logic [WORD_W:0] w_diff;

    assign w_sum  = {1'b0, i_dst_val} + {1'b0, i_src_val};
    // Top bit of the extended difference is the borrow out.
    assign w_diff = {1'b0, i_dst_val} - {1'b0, i_src_val};

    always_comb begin
        o_res = '0;
        o_c   = i_c;
        o_we  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_res = w_sum[WORD_W-1:0];
                o_c   = w_sum[WORD_W];
                o_we  = 1'b1;
            end
            OP_SUB: begin
                o_res = w_diff[WORD_W-1:0];
                o_c   = w_diff[WORD_W];
                o_we  = 1'b1;
            end
            OP_AND: begin
                o_res = i_dst_val & i_src_val;
                o_we  = 1'b1;
            end
            OP_NOT: begin
                o_res = ~i_src_val;
                o_we  = 1'b1;
            end
            OP_CMP: begin
                o_res = w_diff[WORD_W-1:0];
                o_c   = w_diff[WORD_W];
            end
            default: ;
        endcase
    end

    assign o_z = (o_res == '0);

endmodule

// File: rtl/risc_spm_gen2.sv
// Multi-cycle RISC stored-program machine with a single req/ack memory port
// shared by instruction fetch, operand fetch and data access.
module risc_spm_gen2
    import risc_spm_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [WORD_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    localparam int RSEL_W = rsel_w(WORD_W);
    localparam int NREG   = 2**RSEL_W;

    state_e            r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_ir;
    logic [WORD_W-1:0] r_ar;
    logic [WORD_W-1:0] r_regs [NREG];
    logic              r_z;
    logic              r_c;
    logic              r_illegal;
    logic              r_halted;

    logic [OPC_W-1:0]  w_op;
    logic [RSEL_W-1:0] w_src;
    logic [RSEL_W-1:0] w_dst;
    logic [WORD_W-1:0] w_pc_inc;
    logic              w_taken;
    logic [WORD_W-1:0] w_alu_res;
    logic              w_alu_c;
    logic              w_alu_z;
    logic              w_alu_we;

    assign w_op     = r_ir[WORD_W-1 -: OPC_W];
    assign w_src    = r_ir[2*RSEL_W-1:RSEL_W];
    assign w_dst    = r_ir[RSEL_W-1:0];
    assign w_pc_inc = r_pc + 1'b1;
    assign w_taken  = ((w_op == OP_BRZ) && r_z) || ((w_op == OP_BRC) && r_c);

    risc_alu_gen2 #(.WORD_W(WORD_W)) u_alu (
        .i_op      (w_op),
        .i_dst_val (r_regs[w_dst]),
        .i_src_val (r_regs[w_src]),
        .i_c       (r_c),
        .o_res     (w_alu_res),
        .o_c       (w_alu_c),
        .o_z       (w_alu_z),
        .o_we      (w_alu_we)
    );

    // Memory port is a pure decode of registered state, so address/data hold
    // steady for the whole wait and drop the cycle after a reset edge.
    assign mem_req   = (r_state == S_FETCH) || (r_state == S_OPND) || (r_state == S_DATA);
    assign mem_we    = (r_state == S_DATA) && (w_op == OP_WR);
    assign mem_addr  = (r_state == S_DATA) ? r_ar : r_pc;
    assign mem_wdata = r_regs[w_src];
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign illegal   = r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_ar      <= '0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_illegal <= 1'b0;
            r_halted  <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;

                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_pc    <= w_pc_inc;
                        r_state <= S_DEC;
                    end
                end

                S_DEC: begin
                    case (w_op)
                        OP_NOP: r_state <= S_FETCH;
                        OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_CMP: r_state <= S_EX;
                        OP_RD, OP_WR, OP_LDI, OP_BR: r_state <= S_OPND;
                        OP_BRZ, OP_BRC: begin
                            // Untaken: step over the target word.
                            if (w_taken) r_state <= S_OPND;
                            else begin
                                r_pc    <= w_pc_inc;
                                r_state <= S_FETCH;
                            end
                        end
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: begin
                            r_illegal <= 1'b1;
                            r_halted  <= 1'b1;
                            r_state   <= S_HALT;
                        end
                    endcase
                end

                S_EX: begin
                    if (w_alu_we) r_regs[w_dst] <= w_alu_res;
                    r_z     <= w_alu_z;
                    r_c     <= w_alu_c;
                    r_state <= S_FETCH;
                end

                S_OPND: begin
                    if (mem_ack) begin
                        case (w_op)
                            OP_LDI: begin
                                r_regs[w_dst] <= mem_rdata;
                                r_pc          <= w_pc_inc;
                                r_state       <= S_FETCH;
                            end
                            OP_RD, OP_WR: begin
                                r_ar    <= mem_rdata;
                                r_pc    <= w_pc_inc;
                                r_state <= S_DATA;
                            end
                            default: begin
                                r_pc    <= mem_rdata;
                                r_state <= S_FETCH;
                            end
                        endcase
                    end
                end

                S_DATA: begin
                    if (mem_ack) begin
                        if (w_op == OP_RD) r_regs[w_dst] <= mem_rdata;
                        r_state <= S_FETCH;
                    end
                end

                S_HALT: r_state <= S_HALT;

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
